// File: rtl/thresholding_cfg_axilite.sv
// AXI4-Lite slave that turns register accesses into one-cycle strobes on the thresholding config port.
// Optional macro THRESHOLDING_CFG_RD_TIMEOUT_EN bounds the readback wait to RD_TIMEOUT cycles.
module thresholding_cfg_axilite #(
  parameter int ADDR_BITS  = 16,
  parameter int K          = 16,
  parameter bit SIGNED     = 1'b1,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [ADDR_BITS-1:0] s_awaddr,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [31:0]          s_wdata,
  input  logic [3:0]           s_wstrb,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  input  logic [ADDR_BITS-1:0] s_araddr,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [31:0]          s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 cfg_en,
  output logic                 cfg_we,
  output logic [ADDR_BITS-3:0] cfg_a,
  output logic [K-1:0]         cfg_d,
  input  logic                 cfg_rack,
  input  logic [K-1:0]         cfg_q
);

  typedef enum logic [1:0] {IDLE, WRESP, RWAIT, RRESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         NBYTES      = (K + 7) / 8;
  localparam logic [3:0] STRB_MASK   = 4'((1 << NBYTES) - 1);

  state_t state, state_n;
  logic alive;
  logic aw_full, w_full, ar_full;
  logic [ADDR_BITS-3:0] aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic prio_rd, prio_rd_n;
  logic grant_wr, grant_rd, wr_elig, rd_elig, strb_ok, timeout, late_ok;
  logic cfg_en_n, cfg_we_n, bvalid_n, rvalid_n;
  logic [ADDR_BITS-3:0] cfg_a_n;
  logic [K-1:0] cfg_d_n;
  logic [1:0] bresp_n, rresp_n;
  logic [31:0] rdata_n;
  logic unused_bits;

  function automatic logic [31:0] extend_q(input logic [K-1:0] q);
    logic [31:0] r;
    r = 32'(q);
    for (int i = K; i < 32; i++) r[i] = SIGNED & q[K-1];
    return r;
  endfunction

  // alive keeps every ready low while reset is held
  assign s_awready = alive & ~aw_full;
  assign s_wready  = alive & ~w_full;
  assign s_arready = alive & ~ar_full;
  assign wr_elig   = aw_full & w_full;
  assign rd_elig   = ar_full;
  assign strb_ok   = ((w_strb_q & STRB_MASK) == STRB_MASK);
  assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], w_data_q, w_strb_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive     <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      alive <= 1'b1;
      if (grant_wr) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (s_awvalid && s_awready) begin
          aw_full   <= 1'b1;
          aw_addr_q <= s_awaddr[ADDR_BITS-1:2];
        end
        if (s_wvalid && s_wready) begin
          w_full   <= 1'b1;
          w_data_q <= s_wdata;
          w_strb_q <= s_wstrb;
        end
      end
      if (grant_rd) begin
        ar_full <= 1'b0;
      end else if (s_arvalid && s_arready) begin
        ar_full   <= 1'b1;
        ar_addr_q <= s_araddr[ADDR_BITS-1:2];
      end
    end
  end

`ifdef THRESHOLDING_CFG_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = (state == RWAIT) && !cfg_rack && (to_cnt == TW'(RD_TIMEOUT - 1));

  // late_ok marks a timed-out read whose acknowledge may still straggle in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      late_ok <= 1'b0;
    end else if (grant_rd) begin
      to_cnt  <= '0;
      late_ok <= 1'b0;
    end else if (state == RWAIT) begin
      to_cnt <= to_cnt + TW'(1);
      if (timeout) late_ok <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign late_ok        = 1'b0;
  assign unused_timeout = ^32'(RD_TIMEOUT);
`endif

  // Arbitration pointer only flips when both requests contend
  always_comb begin
    state_n   = state;
    prio_rd_n = prio_rd;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    cfg_en_n  = 1'b0;
    cfg_we_n  = 1'b0;
    cfg_a_n   = '0;
    cfg_d_n   = '0;
    bvalid_n  = s_bvalid;
    bresp_n   = s_bresp;
    rvalid_n  = s_rvalid;
    rresp_n   = s_rresp;
    rdata_n   = s_rdata;
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || !prio_rd)) grant_wr = 1'b1;
        else if (rd_elig)                      grant_rd = 1'b1;
        if (wr_elig && rd_elig) prio_rd_n = grant_wr;
        if (grant_wr) begin
          state_n = WRESP;
          if (strb_ok) begin
            cfg_en_n = 1'b1;
            cfg_we_n = 1'b1;
            cfg_a_n  = aw_addr_q;
            cfg_d_n  = w_data_q[K-1:0];
          end else begin
            bvalid_n = 1'b1;
            bresp_n  = RESP_SLVERR;
          end
        end else if (grant_rd) begin
          state_n  = RWAIT;
          cfg_en_n = 1'b1;
          cfg_a_n  = ar_addr_q;
        end
      end
      WRESP: begin
        if (s_bvalid && s_bready) begin
          bvalid_n = 1'b0;
          state_n  = IDLE;
        end else if (cfg_en) begin
          bvalid_n = 1'b1;
          bresp_n  = RESP_OKAY;
        end
      end
      RWAIT: begin
        if (cfg_rack) begin
          rdata_n  = extend_q(cfg_q);
          rresp_n  = RESP_OKAY;
          rvalid_n = 1'b1;
          state_n  = RRESP;
        end else if (timeout) begin
          rdata_n  = 32'hDEAD_BEEF;
          rresp_n  = RESP_SLVERR;
          rvalid_n = 1'b1;
          state_n  = RRESP;
        end
      end
      RRESP: begin
        if (s_rvalid && s_rready) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prio_rd  <= 1'b0;
      cfg_en   <= 1'b0;
      cfg_we   <= 1'b0;
      cfg_a    <= '0;
      cfg_d    <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
      s_rvalid <= 1'b0;
      s_rresp  <= RESP_OKAY;
      s_rdata  <= '0;
    end else begin
      state    <= state_n;
      prio_rd  <= prio_rd_n;
      cfg_en   <= cfg_en_n;
      cfg_we   <= cfg_we_n;
      cfg_a    <= cfg_a_n;
      cfg_d    <= cfg_d_n;
      s_bvalid <= bvalid_n;
      s_bresp  <= bresp_n;
      s_rvalid <= rvalid_n;
      s_rresp  <= rresp_n;
      s_rdata  <= rdata_n;
    end
  end

`ifndef SYNTHESIS
  rack_outside_rwait: assert property (@(posedge clk) disable iff (rst)
    !(cfg_rack && (state != RWAIT) && !late_ok));
`endif

endmodule

// File: tb/tb_thresholding_cfg_axilite.sv
// Directed, table-driven bench for thresholding_cfg_axilite (ADDR_BITS=16, K=16, SIGNED=1, RD_TIMEOUT=8).
// Define THRESHOLDING_CFG_RD_TIMEOUT_EN to also exercise the readback timeout.
module tb_thresholding_cfg_axilite;

  logic clk, rst;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [15:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic cfg_en, cfg_we, cfg_rack;
  logic [13:0] cfg_a;
  logic [15:0] cfg_d, cfg_q;

  thresholding_cfg_axilite #(.ADDR_BITS(16), .K(16), .SIGNED(1'b1), .RD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
    .cfg_rack(cfg_rack), .cfg_q(cfg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    logic [15:0] q;
    bit          exp_en;
    logic [13:0] exp_a;
    logic [15:0] exp_d;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  int n_vec = 0;
  int n_miss = 0;

  // Config-port monitor: counts strobes, latches the last one, flags back-to-back strobes
  int en_count = 0;
  int gap_viol = 0;
  logic prev_en = 1'b0;
  logic mon_we = 1'b0;
  logic [13:0] mon_a = '0;
  logic [15:0] mon_d = '0;
  always @(negedge clk) begin
    if (cfg_en) begin
      en_count <= en_count + 1;
      mon_we   <= cfg_we;
      mon_a    <= cfg_a;
      mon_d    <= cfg_d;
      if (prev_en) gap_viol <= gap_viol + 1;
    end
    prev_en <= cfg_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string name, input bit is_wr, input logic [15:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input int delay,
                         input logic [15:0] q, input bit exp_en, input logic [13:0] exp_a,
                         input logic [15:0] exp_d, input logic [1:0] exp_resp,
                         input logic [31:0] exp_rdata);
    vecs[i].name = name;   vecs[i].is_wr = is_wr; vecs[i].addr = addr;
    vecs[i].data = data;   vecs[i].strb = strb;   vecs[i].delay = delay;
    vecs[i].q = q;         vecs[i].exp_en = exp_en; vecs[i].exp_a = exp_a;
    vecs[i].exp_d = exp_d; vecs[i].exp_resp = exp_resp; vecs[i].exp_rdata = exp_rdata;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_ctrl"}, {25'd0, s_awready, s_wready, s_bvalid, s_arready,
                                  s_rvalid, cfg_en, cfg_we}, 32'd0);
    check_output({tag, "_cfg_a"}, {18'd0, cfg_a}, 32'd0);
    check_output({tag, "_cfg_d"}, {16'd0, cfg_d}, 32'd0);
    check_output({tag, "_resp"}, {28'd0, s_bresp, s_rresp}, 32'd0);
    check_output({tag, "_rdata"}, s_rdata, 32'd0);
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!cfg_en && n < 30) begin tick(); n++; end
    check_output({name, "_en_seen"}, {31'd0, cfg_en}, 32'd1);
  endtask

  task automatic send_ar(input logic [15:0] addr);
    int n = 0;
    bit go;
    s_araddr = addr;
    s_arvalid = 1'b1;
    do begin
      go = s_arready;
      tick();
      n++;
    end while (!go && n < 30);
    s_arvalid = 1'b0;
    check_output("ar_accept", {31'd0, go}, 32'd1);
  endtask

  task automatic rack_respond(input logic [15:0] q, output logic [31:0] rdata, output logic [1:0] rresp);
    int n = 0;
    cfg_rack = 1'b1;
    cfg_q = q;
    tick();
    cfg_rack = 1'b0;
    cfg_q = '0;
    while (!s_rvalid && n < 30) begin tick(); n++; end
    check_output("rvalid_seen", {31'd0, s_rvalid}, 32'd1);
    rdata = s_rdata;
    rresp = s_rresp;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    bit aw_pend = 1'b1, w_pend = 1'b1, aw_go, w_go;
    int n = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    while ((aw_pend || w_pend) && n < 30) begin
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      tick();
      n++;
      if (aw_go) begin s_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_go)  begin s_wvalid = 1'b0;  w_pend = 1'b0;  end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 30) begin tick(); n++; end
    check_output("bvalid_seen", {31'd0, s_bvalid}, 32'd1);
    resp = s_bresp;
    tick();
  endtask

  task automatic do_read(input logic [15:0] addr, input int delay, input logic [15:0] q,
                         output logic [31:0] rdata, output logic [1:0] rresp);
    send_ar(addr);
    wait_en("rd");
    repeat (delay) tick();
    rack_respond(q, rdata, rresp);
    tick();
  endtask

  task automatic apply_stimulus();
    logic [1:0] resp;
    logic [31:0] rdata;
    int en0;
    for (int i = 0; i < 8; i++) begin
      en0 = en_count;
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        rdata = vecs[i].exp_rdata;
      end else begin
        do_read(vecs[i].addr, vecs[i].delay, vecs[i].q, rdata, resp);
      end
      check_output({vecs[i].name, "_en_pulses"}, en_count - en0, {31'd0, vecs[i].exp_en});
      if (vecs[i].exp_en) begin
        check_output({vecs[i].name, "_we"}, {31'd0, mon_we}, {31'd0, vecs[i].is_wr});
        check_output({vecs[i].name, "_cfg_a"}, {18'd0, mon_a}, {18'd0, vecs[i].exp_a});
        check_output({vecs[i].name, "_cfg_d"}, {16'd0, mon_d}, {16'd0, vecs[i].exp_d});
      end
      check_output({vecs[i].name, "_resp"}, {30'd0, resp}, {30'd0, vecs[i].exp_resp});
      if (!vecs[i].is_wr) check_output({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
    end
  endtask

  initial begin
    logic [31:0] rdata;
    logic [1:0] rresp;
    int en0, bad, ar_bad, lat;
    bit ar_latched, ar_go;

    rst = 1'b1;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_bready = 1'b1;
    s_arvalid = 0; s_araddr = '0; s_rready = 1'b1; cfg_rack = 0; cfg_q = '0;

    set_vec(0, "wr_basic",   1, 16'h0010, 32'h0000_00AB, 4'hF, 0, 16'h0,    1, 14'h0004, 16'h00AB, 2'b00, 32'h0);
    set_vec(1, "wr_lowbits", 1, 16'h0123, 32'h1234_5678, 4'h3, 0, 16'h0,    1, 14'h0048, 16'h5678, 2'b00, 32'h0);
    set_vec(2, "wr_strb_hi", 1, 16'h0020, 32'h0000_1111, 4'hC, 0, 16'h0,    0, 14'h0,    16'h0,    2'b10, 32'h0);
    set_vec(3, "wr_strb_b0", 1, 16'h0024, 32'h0000_2222, 4'h1, 0, 16'h0,    0, 14'h0,    16'h0,    2'b10, 32'h0);
    set_vec(4, "rd_signed",  0, 16'h0008, 32'h0,         4'h0, 3, 16'hFFF0, 1, 14'h0002, 16'h0,    2'b00, 32'hFFFF_FFF0);
    set_vec(5, "rd_pos_top", 0, 16'hFFFE, 32'h0,         4'h0, 0, 16'h7FFF, 1, 14'h3FFF, 16'h0,    2'b00, 32'h0000_7FFF);
    set_vec(6, "rd_neg_min", 0, 16'h0004, 32'h0,         4'h0, 7, 16'h8000, 1, 14'h0001, 16'h0,    2'b00, 32'hFFFF_8000);
    set_vec(7, "wr_top",     1, 16'hFFFC, 32'hFFFF_FFFF, 4'hF, 0, 16'h0,    1, 14'h3FFF, 16'hFFFF, 2'b00, 32'h0);

    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Exact write timing: strobe one cycle after acceptance, response one cycle after strobe
    s_awaddr = 16'h0010; s_wdata = 32'h0000_00AB; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check_output("lat_ready_low", {30'd0, s_awready, s_wready}, 32'd0);
    tick();
    check_output("lat_en", {30'd0, cfg_en, cfg_we}, 32'd3);
    check_output("lat_a_d", {2'd0, cfg_a, cfg_d}, {2'd0, 14'h0004, 16'h00AB});
    check_output("lat_bvalid_early", {31'd0, s_bvalid}, 32'd0);
    tick();
    check_output("lat_bvalid", {29'd0, cfg_en, s_bvalid, s_bresp[1]}, 32'd2);
    tick();
    check_output("lat_bdone", {31'd0, s_bvalid}, 32'd0);

    apply_stimulus();

    // Contention: first pair goes to the write, the next pair to the read
    s_awaddr = 16'h0020; s_wdata = 32'h11; s_wstrb = 4'hF; s_araddr = 16'h0030;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    wait_en("rr1_first");
    check_output("rr1_first", {17'd0, cfg_we, cfg_a}, {17'd0, 1'b1, 14'h0008});
    tick();
    wait_en("rr1_second");
    check_output("rr1_second", {17'd0, cfg_we, cfg_a}, {17'd0, 1'b0, 14'h000C});
    rack_respond(16'h0042, rdata, rresp);
    check_output("rr1_rdata", rdata, 32'h0000_0042);
    tick();
    s_awaddr = 16'h0024; s_wdata = 32'h22; s_araddr = 16'h0034;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    wait_en("rr2_first");
    check_output("rr2_first", {17'd0, cfg_we, cfg_a}, {17'd0, 1'b0, 14'h000D});
    rack_respond(16'h0001, rdata, rresp);
    tick();
    wait_en("rr2_second");
    check_output("rr2_second", {1'b0, cfg_we, cfg_a, cfg_d}, {1'b0, 1'b1, 14'h0009, 16'h0022});
    tick(); tick(); tick();

    // Read response backpressure with a second read queued behind it
    s_rready = 1'b0;
    send_ar(16'h0040);
    wait_en("bp");
    rack_respond(16'h1234, rdata, rresp);
    en0 = en_count; bad = 0; ar_bad = 0; ar_latched = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin s_araddr = 16'h0044; s_arvalid = 1'b1; end
      ar_go = s_arvalid && s_arready;
      tick();
      if (ar_go) begin s_arvalid = 1'b0; ar_latched = 1'b1; end
      if (s_rdata !== 32'h0000_1234 || s_rvalid !== 1'b1 || s_rresp !== 2'b00) bad++;
      if (ar_latched && s_arready) ar_bad++;
    end
    check_output("bp_rdata_stable", bad, 32'd0);
    check_output("bp_ar_latched", {31'd0, ar_latched}, 32'd1);
    check_output("bp_arready_low", ar_bad, 32'd0);
    check_output("bp_no_en", en_count - en0, 32'd0);
    s_rready = 1'b1;
    tick();
    check_output("bp_rdone", {31'd0, s_rvalid}, 32'd0);
    wait_en("bp_next");
    check_output("bp_next_a", {17'd0, cfg_we, cfg_a}, {17'd0, 1'b0, 14'h0011});
    rack_respond(16'hFFFF, rdata, rresp);
    check_output("bp_next_rdata", rdata, 32'hFFFF_FFFF);
    tick();

    // Reset while waiting for readback drops the read
    send_ar(16'h0050);
    wait_en("rst_rwait");
    tick();
    rst = 1'b1; cfg_rack = 1'b1; cfg_q = 16'h5555;
    #1;
    check_reset_outputs("rst_rwait");
    tick();
    rst = 1'b0; cfg_rack = 1'b0; cfg_q = '0;
    en0 = en_count; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_rvalid !== 1'b0) bad++;
    end
    check_output("rst_rwait_no_rvalid", bad, 32'd0);
    check_output("rst_rwait_no_en", en_count - en0, 32'd0);
    do_read(16'h000C, 1, 16'h0080, rdata, rresp);
    check_output("rst_recover", {rresp, mon_a, rdata[15:0]}, {2'b00, 14'h0003, 16'h0080});

`ifdef THRESHOLDING_CFG_RD_TIMEOUT_EN
    s_rready = 1'b0;
    send_ar(16'h0060);
    wait_en("to");
    lat = 0;
    while (!s_rvalid && lat < 30) begin tick(); lat++; end
    check_output("to_latency", lat, 32'd8);
    check_output("to_rdata", s_rdata, 32'hDEAD_BEEF);
    check_output("to_rresp", {30'd0, s_rresp}, 32'd2);
    cfg_rack = 1'b1; cfg_q = 16'h0001;
    tick();
    cfg_rack = 1'b0; cfg_q = '0;
    check_output("to_late_rack", {s_rresp, s_rdata[29:0]}, {2'b10, 30'h1EAD_BEEF});
    s_rready = 1'b1;
    tick();
    check_output("to_rdone", {31'd0, s_rvalid}, 32'd0);
`endif

    check_output("en_gap", gap_viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/thresholding_cfg_axilite.md
Name: thresholding_cfg_axilite

Overview:
- AXI4-Lite slave that converts register reads and writes into single-cycle transactions on the threshold-configuration port (cfg_en/cfg_we/cfg_a/cfg_d, readback via cfg_rack/cfg_q) of the thresholding pipeline directly downstream.
- Holds at most one transaction in flight.
- Waits the variable pipeline latency for readback data before it returns the AXI read response.

Parameters:
ADDR_BITS, 16, AXI byte-address width; cfg_a = word index = addr[ADDR_BITS-1:2]
K, 16, threshold precision; K <= 32
SIGNED, 1, 1: sign-extend cfg_q into RDATA; 0: zero-extend
RD_TIMEOUT, 64, readback wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
s_awvalid/s_awready  in/out  1  write-address handshake
s_awaddr  in  ADDR_BITS  write byte address
s_wvalid/s_wready  in/out  1  write-data handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_bvalid/s_bready  out/in  1  write-response handshake
s_bresp  out  2  write response
s_arvalid/s_arready  in/out  1  read-address handshake
s_araddr  in  ADDR_BITS  read byte address
s_rvalid/s_rready  out/in  1  read-response handshake
s_rdata  out  32  read data
s_rresp  out  2  read response
cfg_en  out  1  config strobe, one cycle per transaction
cfg_we  out  1  1 = write, 0 = readback
cfg_a  out  ADDR_BITS-2  threshold word address
cfg_d  out  K  threshold write value
cfg_rack  in  1  readback acknowledge from the pipeline
cfg_q  in  K  readback value, valid while cfg_rack is high

Behaviour:
- Reset is asynchronous active-high. While rst is asserted all outputs are 0: every ready and valid signal, cfg_en, cfg_we, cfg_a, cfg_d, s_bresp, s_rresp and s_rdata.
- Input latches:
  - s_awready is high while the AW holding register is empty.
  - s_wready is high while the W holding register is empty.
  - AW and W are accepted independently, in any order.
  - s_arready is high while the AR holding register is empty.
- FSM states: IDLE, WRESP, RWAIT, RRESP.
- IDLE:
  - A write is eligible when both AW and W are held; a read is eligible when AR is held.
  - If both are eligible, grant the one not granted last (round-robin); after reset the write wins.
- IDLE -> WRESP (write grant), registered outputs asserted the next cycle:
  - cfg_en=1, cfg_we=1, cfg_a=awaddr[ADDR_BITS-1:2], cfg_d=wdata[K-1:0], for exactly one cycle.
  - The AW and W latches are cleared.
- Write strobe check:
  - If any wstrb bit covering bits [K-1:0] is 0, no cfg_en is issued and s_bresp=SLVERR (2'b10).
  - Otherwise s_bresp=OKAY.
- WRESP: s_bvalid is asserted the cycle after the cfg_en pulse (or directly on a rejected write) and held until s_bready; then go to IDLE.
- IDLE -> RWAIT (read grant):
  - Next cycle: cfg_en=1, cfg_we=0, cfg_a=araddr[ADDR_BITS-1:2], cfg_d=0, for one cycle.
  - The AR latch is cleared.
- RWAIT:
  - Wait any number of cycles for cfg_rack.
  - On cfg_rack, capture cfg_q, extended to 32 bits per SIGNED, into s_rdata with s_rresp=OKAY; go to RRESP.
- RRESP: s_rvalid is held until s_rready; s_rdata and s_rresp stay stable; then go to IDLE.
- cfg_rack outside RWAIT is ignored; simulation assertion error.
- cfg_en is never asserted outside the single issue cycle. Consecutive cfg_en pulses are separated by at least 2 cycles, so the stream path downstream is stalled for only one cycle per transaction.
- Boundary cases:
  - s_bready or s_rready already high when valid rises: the response completes in that cycle; the FSM is in IDLE next cycle.
  - New AW/W/AR are accepted into empty latches during WRESP, RWAIT and RRESP, but not granted until IDLE.
  - Reset during RWAIT drops the pending read; a late cfg_rack after reset is ignored.
- Address bits [1:0] are ignored.

Optional Feature:
- Macro: THRESHOLDING_CFG_RD_TIMEOUT_EN.
- Defined:
  - A counter starts on entry to RWAIT.
  - If RD_TIMEOUT cycles pass without cfg_rack, go to RRESP with s_rdata=32'hDEAD_BEEF and s_rresp=SLVERR.
  - A cfg_rack arriving later is ignored.
- Undefined: no counter; RWAIT waits indefinitely.

Test Plan:
- Write: AW addr 0x0010 and W 0x0000_00AB (wstrb 4'hF) in the same cycle -> next cycle cfg_en=1, cfg_we=1, cfg_a=4, cfg_d=0x00AB; BVALID one cycle later with OKAY.
- Signed readback (K=16, SIGNED=1): AR 0x0008; cfg_rack with cfg_q=16'hFFF0 three cycles after cfg_en -> RDATA=0xFFFF_FFF0, RRESP OKAY; single cfg_en, cfg_we=0, cfg_a=2.
- Simultaneous write and read eligible after reset -> write issued first, then the read; the next simultaneous pair issues the read first.
- wstrb=4'b1100 with K=16 -> no cfg_en; BRESP=SLVERR.
- Backpressure: s_rready held low 10 cycles in RRESP; a new AR arrives meanwhile -> RDATA stable, arready drops after the AR is latched, no cfg_en until the response completes.
- Timeout (macro defined, RD_TIMEOUT=8): no cfg_rack -> RVALID after 8 wait cycles, RDATA=0xDEAD_BEEF, RRESP=SLVERR; a late cfg_rack is ignored.
